// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM state encoding and bit-period rounding
package uart_pkg;

  localparam int DEFAULT_CLK_HZ = 12_000_000;
  localparam int DEFAULT_BAUD   = 115_200;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  // Clocks per bit, rounded to nearest; the transmitter uses the same formula.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - serial line synchroniser with 2-of-3 majority filter and previous sample
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic sample,
  output logic prev_sample
);

  logic       s1;
  logic       s2;
  logic [2:0] hist;

  // Synchronise, keep a short history and remember the last filtered sample.
  // Everything resets to 0 so a line that is low at reset release never looks
  // like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      hist        <= 3'b000;
      prev_sample <= 1'b0;
    end else begin
      s1          <= line;
      s2          <= s1;
      hist        <= {hist[1:0], s2};
      prev_sample <= sample;
    end
  end

  assign sample = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-bit async serial receiver with holding register; parity option UART_RX_PARITY_EN
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = DEFAULT_CLK_HZ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_n_i,
  input  logic       uart_rx_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  input  logic       uart_rd_i,
  output logic       uart_busy_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CPB / 2);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          sample;
  logic          prev_sample;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [7:0]    dat;
  logic          valid;
  logic          frame_err;
  logic          overrun;
  logic          parity_err;

  uart_rx_sync u_sync (
    .clk         (sys_clk_i),
    .rst_n       (sys_rst_n_i),
    .line        (uart_rx_i),
    .sample      (sample),
    .prev_sample (prev_sample)
  );

  // Frame FSM, bit timing, shift register, holding register and error pulses.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      dat        <= 8'h00;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      cnt        <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

      // A read empties the register unless a commit below refills it.
      if (valid && uart_rd_i) valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (prev_sample && !sample) begin
            cnt   <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cnt == CNT_MID) begin
            if (sample) begin
              state <= ST_IDLE;
            end else begin
              cnt     <= '0;
              bit_idx <= 3'd0;
              state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            shreg   <= {sample, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= PAR_EN ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (cnt == CNT_LAST) begin
            par_bit <= sample;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            if (!sample) begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end else begin
              // Leave half a bit early so a back-to-back start edge is seen.
              state <= ST_IDLE;
              if (PAR_EN && (par_bit != (^shreg ^ PARITY_ODD))) begin
                parity_err <= 1'b1;
              end else if (!valid || uart_rd_i) begin
                dat   <= shreg;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
        end
        ST_BREAK: begin
          if (sample) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign uart_dat_o   = dat;
  assign uart_valid_o = valid;
  assign uart_busy_o  = (state != ST_IDLE);
  assign frame_err_o  = frame_err;
  assign overrun_o    = overrun;
  assign parity_err_o = parity_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with random and directed serial frames
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_HZ     = 12_000_000;
  localparam int BAUD       = 115_200;
  localparam bit PARITY_ODD = 1'b0;
  localparam int CPB        = (CLK_HZ + BAUD / 2) / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NBITS  = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NBITS  = 10;
`endif
  // Good byte is visible about (frame bits - 0.5) bit times plus 3 clocks after the start edge.
  localparam int LAT_NOM = ((2 * NBITS - 1) * CPB) / 2 + 3;

  typedef enum int {EV_BYTE, EV_FRAME, EV_OVERRUN, EV_PARITY} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t expq[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dat;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int auto_rd = 1;
  int rd_at = -1;
  int last_commit = -1;

  logic       pv = 1'b0;
  logic [7:0] pd = 8'h00;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY_ODD(PARITY_ODD)) dut (
    .sys_clk_i    (clk),
    .sys_rst_n_i  (rst_n),
    .uart_rx_i    (rx),
    .uart_dat_o   (dat),
    .uart_valid_o (valid),
    .uart_rd_i    (rd),
    .uart_busy_o  (busy),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun),
    .parity_err_o (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, got, lo, hi);
    end
  endtask

  task automatic check_event(input ev_kind_t k, input logic [7:0] d, input string nm);
    ev_t e;
    total++;
    if (expq.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected event kind=%0d data=%02h, expected no event", nm, k, d);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || (k == EV_BYTE && e.data != d)) begin
        bad++;
        $display("FAIL %s: got kind=%0d data=%02h, expected kind=%0d data=%02h",
                 nm, k, d, e.kind, e.data);
      end
    end
  endtask

  // Reference outcome of one frame, from the protocol rules.
  task automatic expect_frame(input logic [7:0] d, input bit stop, input bit flip, input bit full);
    ev_t e;
    e.data = d;
    if (!stop)               e.kind = EV_FRAME;
    else if (PAR_EN && flip) e.kind = EV_PARITY;
    else if (full)           e.kind = EV_OVERRUN;
    else                     e.kind = EV_BYTE;
    expq.push_back(e);
  endtask

  task automatic bit_time();
    repeat (CPB) @(negedge clk);
  endtask

  // Called right after a negedge; leaves rx at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit flip);
    rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      bit_time();
    end
    if (PAR_EN) begin
      rx = (^d) ^ PARITY_ODD ^ flip;
      bit_time();
    end
    rx = stop;
    bit_time();
  endtask

  // Consumer: automatic one-cycle reads, or a read scheduled for a given cycle.
  always @(negedge clk) begin
    rd = ((auto_rd != 0) && valid && !rd) || (cyc == rd_at);
  end

  // Monitor: every observable event must match the head of the expected queue.
  always @(negedge clk) begin
    if (valid && (!pv || dat != pd)) begin
      last_commit = cyc;
      check_event(EV_BYTE, dat, "byte");
    end
    if (frame_err)  check_event(EV_FRAME, 8'h00, "frame_err");
    if (overrun)    check_event(EV_OVERRUN, 8'h00, "overrun");
    if (parity_err) check_event(EV_PARITY, 8'h00, "parity_err");
    pv = valid;
    pd = dat;
  end

  initial begin
    int c0;
    int lat;
    int nbusy;
    logic [7:0] d;
    bit stop;
    bit flip;

    repeat (5) @(negedge clk);
    check("reset_valid", valid, 0);
    check("reset_dat", dat, 0);
    check("reset_busy", busy, 0);
    check("reset_pulses", {frame_err, overrun, parity_err}, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Single byte, with latency from start edge to valid.
    c0 = cyc;
    expect_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    lat = last_commit - c0;
    check_rng("a5_latency", lat, LAT_NOM - 8, LAT_NOM + 8);
    bit_time();

    // Short glitch: a false start that only raises busy briefly.
    nbusy = 0;
    rx = 1'b0;
    repeat (40) begin @(negedge clk); if (busy) nbusy++; end
    rx = 1'b1;
    repeat (160) begin @(negedge clk); if (busy) nbusy++; end
    check_rng("glitch_busy_cycles", nbusy, 45, 65);
    check("glitch_busy_end", busy, 0);
    check("glitch_no_valid", valid, 0);

    // Bad stop followed by a long break, then a good byte.
    expect_frame(8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0);
    repeat (19) bit_time();
    check("break_busy", busy, 1);
    rx = 1'b1;
    bit_time();
    check("break_no_valid", valid, 0);
    expect_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    bit_time();

    // Back to back with no read: second byte overruns.
    auto_rd = 0;
    expect_frame(8'h11, 1'b1, 1'b0, 1'b0);
    expect_frame(8'h22, 1'b1, 1'b0, 1'b1);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    bit_time();
    check("ovr_dat_kept", dat, 8'h11);
    check("ovr_valid", valid, 1);
    auto_rd = 1;
    repeat (4) @(negedge clk);
    auto_rd = 0;
    check("ovr_read_clears", valid, 0);

    // Back to back with a read on the second commit cycle.
    c0 = cyc;
    rd_at = c0 + NBITS * CPB + lat - 1;
    expect_frame(8'h11, 1'b1, 1'b0, 1'b0);
    expect_frame(8'h22, 1'b1, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    bit_time();
    rd_at = -1;
    check("rdcommit_dat", dat, 8'h22);
    check("rdcommit_valid", valid, 1);
    auto_rd = 1;
    repeat (4) @(negedge clk);

    // Reset in the middle of a frame with the line low.
    auto_rd = 0;
    expect_frame(8'h77, 1'b1, 1'b0, 1'b0);
    send_frame(8'h77, 1'b1, 1'b0);
    bit_time();
    check("pre_reset_valid", valid, 1);
    rx = 1'b0;
    repeat (CPB * 5 / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", valid, 0);
    check("mid_reset_dat", dat, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_pulses", {frame_err, overrun, parity_err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    auto_rd = 1;
    nbusy = 0;
    repeat (5 * CPB) begin @(negedge clk); if (busy || valid) nbusy++; end
    check("low_after_reset_idle", nbusy, 0);
    rx = 1'b1;
    bit_time();
    expect_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    bit_time();

`ifdef UART_RX_PARITY_EN
    expect_frame(8'h55, 1'b1, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1);
    bit_time();
    check("parity_bad_no_valid", valid, 0);
    expect_frame(8'h55, 1'b1, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    bit_time();
`endif

    // Random frames: data, stop-bit errors, parity errors and gaps.
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      flip = PAR_EN && ($urandom_range(0, 3) == 0);
      expect_frame(d, stop, flip, 1'b0);
      send_frame(d, stop, flip);
      if (!stop) begin
        repeat ($urandom_range(0, 2)) bit_time();
        rx = 1'b1;
        bit_time();
      end else begin
        repeat ($urandom_range(0, 1)) bit_time();
      end
    end

    for (int w = 0; w < 3000 && expq.size() != 0; w++) @(negedge clk);
    check("queue_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8 data bits, LSB first, 1 stop bit. Receive-side counterpart of the existing `uart` transmitter.
- Sits on the clk12 domain of the icebreaker debug path and lets the host send command bytes to the FPGA: frame-dump trigger, window select.
- Presents each received byte through a one-deep holding register with a valid/read handshake.
- Reports framing and overrun errors.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s. Internal localparam CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD, which is 104 at the defaults.
- PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Used only when UART_RX_PARITY_EN is defined.

Ports:
- sys_clk_i  in  1  system clock.
- sys_rst_n_i  in  1  reset, asynchronous, active-low.
- uart_rx_i  in  1  serial line, asynchronous to sys_clk_i, idles high.
- uart_dat_o  out  8  received byte in the holding register.
- uart_valid_o  out  1  holding register full.
- uart_rd_i  in  1  consumer takes the byte this cycle; ignored when uart_valid_o=0.
- uart_busy_o  out  1  receiver is not in IDLE.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_o  out  1  one-cycle pulse: good byte dropped because the holding register was full.
- parity_err_o  out  1  one-cycle pulse: parity mismatch. Tied to 0 without UART_RX_PARITY_EN.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; state IDLE; counters 0.
  - Synchroniser flops reset to 0. A line already low at reset release is therefore never taken as a start bit; a 1 must be observed first.
- Input path:
  - 2-flop synchroniser, then a 3-bit history register.
  - Every "sample" is the 2-of-3 majority of the history register.
- Bit counter: counts 0..CLKS_PER_BIT-1 and wraps to 0.
- States:
  - IDLE: previous synced sample 1 and current 0 -> clear the bit counter, go to START.
  - START: at count CLKS_PER_BIT/2 (mid start bit), sample.
    - Sample 1 -> false start, back to IDLE, no pulse.
    - Sample 0 -> clear the counter, bit index 0, go to DATA.
  - DATA: at count CLKS_PER_BIT-1, sample and shift the bit into bit[7] of the shift register (shift right).
    - After the 8th bit -> STOP (or PARITY when the macro is enabled).
  - STOP: at count CLKS_PER_BIT-1, sample.
    - Sample 1 -> byte good, go to IDLE immediately, half a bit early, so a back-to-back start edge is caught.
    - Sample 0 -> frame_err_o pulse, byte discarded, go to BREAK.
  - BREAK: wait for a synced sample of 1, then go to IDLE. A long break yields exactly one frame_err_o.
- Good-byte commit, on the cycle STOP samples 1:
  - Holding register empty, or uart_rd_i=1 this cycle -> load uart_dat_o, uart_valid_o=1.
  - Otherwise -> keep the old byte, pulse overrun_o, drop the new byte.
- Handshake:
  - uart_valid_o && uart_rd_i with no commit in the same cycle -> uart_valid_o=0 next cycle.
  - uart_dat_o is held until it is replaced.
- Latency: a good byte is visible about 9.5 bit times plus 3 clocks after its start edge. The 3 clocks are synchroniser and majority delay.
- uart_busy_o is high in START, DATA, PARITY, STOP and BREAK.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one bit at count CLKS_PER_BIT-1.
  - Expected parity = XOR of the data bits, XOR PARITY_ODD.
  - At STOP, a bad stop bit takes precedence: frame_err_o pulses only.
  - Otherwise, a parity mismatch pulses parity_err_o and discards the byte, with no overrun check.
- Undefined: 8N1 only; parity_err_o is constant 0.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP, BREAK);
  - default CLK_HZ/BAUD constants;
  - CLKS_PER_BIT rounding formula, shared with the transmitter.
- One sub-module, uart_rx_sync:
  - 2-flop synchroniser, reset to 0;
  - 3-bit history register and majority output;
  - previous-sample output for edge detection.

Test Plan (CLK_HZ=12e6, BAUD=115200, CLKS_PER_BIT=104):
- Send 0xA5 as 8N1 -> uart_valid_o rises about 991 clocks after the start edge; uart_dat_o=0xA5; no error pulses.
- 40-clock low glitch on an idle line -> uart_busy_o high for about 55 clocks, then low; no valid, no errors.
- Byte 0x00 with stop bit low, line held low for 20 bit times -> exactly one frame_err_o pulse, no valid. After the line returns high, 0x3C is received correctly.
- Bytes 0x11 and 0x22 back to back, uart_rd_i=0 -> dat=0x11; overrun_o pulses at the second stop bit; dat stays 0x11.
  - Repeat with uart_rd_i=1 on the commit cycle -> dat=0x22, valid stays 1, no overrun.
- Assert sys_rst_n_i mid-DATA while the line is low -> all outputs 0 immediately. After release, nothing is received until the line goes high. Then 0x5A is received correctly.
- With UART_RX_PARITY_EN and PARITY_ODD=0: send 0x55 with parity bit 1 -> parity_err_o pulses, no valid. Send 0x55 with parity bit 0 -> dat=0x55.
